// File: rtl/shift_serializer.sv
// shift_serializer: framed parallel-to-serial converter with valid/ready load and a one-word holding register.
// Per-word length, bit order and bit period are latched when the word moves from holding register to shifter.
module shift_serializer #(
    parameter int   DATA_WIDTH = 16,
    parameter int   LEN_WIDTH  = 4,
    parameter int   DIV_WIDTH  = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  a_rst_n_i,
    input  logic                  enable_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic [LEN_WIDTH-1:0]  s_len_i,
    input  logic                  s_msb_first_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    output logic                  serial_data_o,
    output logic                  bit_strobe_o,
    output logic                  frame_o,
    output logic                  done_o,
    output logic                  busy_o
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state, state_next;
    logic                  hold_full, hold_msb, msb;
    logic [DATA_WIDTH-1:0] hold_data, sh;
    logic [LEN_WIDTH-1:0]  hold_len, bit_cnt;
    logic [DIV_WIDTH-1:0]  period, per_cnt;
    logic                  accept, tc, last, load;
    logic                  serial, strobe, done;

    always_comb begin
        accept     = s_valid_i & ~hold_full;
        tc         = enable_i & (state == SHIFT) & (per_cnt == period);
        last       = bit_cnt == '0;
        load       = enable_i & hold_full & ((state == IDLE) | (tc & last));
        state_next = load ? SHIFT : (tc & last) ? IDLE : state;
    end

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) state <= IDLE;
        else            state <= state_next;
    end

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_len  <= '0;
            hold_msb  <= 1'b0;
        end else begin
            hold_full <= accept | (hold_full & ~load);
            if (accept) begin
                hold_data <= s_data_i;
                hold_len  <= s_len_i;
                hold_msb  <= s_msb_first_i;
            end
        end
    end

    // MSB-first words are left-aligned so both orders shift out of a fixed end, dropping bits above N.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            sh      <= '0;
            bit_cnt <= '0;
            per_cnt <= '0;
            period  <= '0;
            msb     <= 1'b0;
            serial  <= IDLE_LEVEL;
            strobe  <= 1'b0;
            done    <= 1'b0;
        end else begin
            strobe <= load | (tc & ~last);
            done   <= tc & last;
            if (load) begin
                sh      <= hold_msb ? hold_data << (LEN_WIDTH'(DATA_WIDTH - 1) - hold_len) : hold_data;
                bit_cnt <= hold_len;
                per_cnt <= '0;
                period  <= div_i;
                msb     <= hold_msb;
                serial  <= hold_msb ? hold_data[hold_len] : hold_data[0];
            end else if (tc & ~last) begin
                sh      <= msb ? sh << 1 : sh >> 1;
                bit_cnt <= bit_cnt - 1'b1;
                per_cnt <= '0;
                serial  <= msb ? sh[DATA_WIDTH-2] : sh[1];
            end else if (tc) begin
                per_cnt <= '0;
                serial  <= IDLE_LEVEL;
            end else if (enable_i && state == SHIFT) begin
                per_cnt <= per_cnt + 1'b1;
            end
        end
    end

    assign s_ready_o     = ~hold_full;
    assign serial_data_o = serial;
    assign bit_strobe_o  = strobe;
    assign frame_o       = state == SHIFT;
    assign done_o        = done;
    assign busy_o        = frame_o | hold_full;
endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: directed checks of framing, bit order, bit period, back-to-back, pause and reset.
module tb_shift_serializer;
    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic        s_valid = 1'b0, s_ready, s_msb = 1'b0;
    logic [15:0] s_data = '0;
    logic [3:0]  s_len = '0;
    logic [7:0]  div = '0;
    logic        serial, strobe, frame, done, busy;
    int          total = 0, bad = 0, ndone = 0, nd0;

    shift_serializer dut (
        .clk_i(clk), .a_rst_n_i(rst_n), .enable_i(enable),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .s_len_i(s_len), .s_msb_first_i(s_msb), .div_i(div),
        .serial_data_o(serial), .bit_strobe_o(strobe), .frame_o(frame),
        .done_o(done), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (done) ndone++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_at(input logic [15:0] d, input int n, input logic m, input int i);
        return m ? d[n-i] : d[i];
    endfunction

    task automatic send(input logic [15:0] d, input int n, input logic m, input logic [7:0] dv);
        s_valid = 1'b1; s_data = d; s_len = 4'(n); s_msb = m; div = dv;
        for (int k = 0; k < 200 && !s_ready; k++) @(negedge clk);
        chk("ready_wait", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic expect_frame(input logic [15:0] d, input int n, input logic m, input int dv);
        @(negedge clk);
        for (int i = 0; i <= n; i++)
            for (int c = 0; c <= dv; c++) begin
                chk("bit", serial, bit_at(d, n, m, i));
                chk("strobe", strobe, c == 0);
                chk("frame", frame, 1);
                chk("done_mid", done, 0);
                @(negedge clk);
            end
        chk("end_frame", frame, 0);
        chk("end_done", done, 1);
        chk("end_idle", serial, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        logic [5:0] b2b_ser;
        logic [5:0] b2b_done;
        repeat (2) @(negedge clk);
        chk("rst_ready", s_ready, 1);
        chk("rst_frame", frame, 0);
        rst_n = 1'b1; enable = 1'b1;
        @(negedge clk);
        chk("idle_ready", s_ready, 1);
        chk("idle_serial", serial, 0);
        chk("idle_strobe", strobe, 0);
        chk("idle_frame", frame, 0);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);

        // bit order, single-cycle bits
        send(16'h00C6, 7, 1'b1, 8'd0);
        chk("accept_busy", busy, 1);
        expect_frame(16'h00C6, 7, 1'b1, 0);
        send(16'h00C6, 7, 1'b0, 8'd0);
        expect_frame(16'h00C6, 7, 1'b0, 0);
        // one-bit frame; upper bits ignored
        send(16'hFFFE, 0, 1'b1, 8'd0);
        expect_frame(16'hFFFE, 0, 1'b1, 0);
        // bit period of 4 cycles
        send(16'hFFFF, 15, 1'b1, 8'd3);
        expect_frame(16'hFFFF, 15, 1'b1, 3);

        // back-to-back with s_valid held high
        b2b_ser = 6'b101010; b2b_done = 6'b000100;
        s_valid = 1'b1; s_data = 16'h5; s_len = 4'd2; s_msb = 1'b1; div = 8'd0;
        @(negedge clk);
        chk("b2b_ready0", s_ready, 0);
        s_data = 16'h2;
        @(negedge clk);
        chk("b2b_ready1", s_ready, 1);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) s_valid = 1'b0;
            chk("b2b_bit", serial, b2b_ser[5-i]);
            chk("b2b_frame", frame, 1);
            chk("b2b_strobe", strobe, 1);
            chk("b2b_done", done, b2b_done[5-i]);
            if (i == 1 || i == 2) chk("b2b_wait_ready", s_ready, 0);
            @(negedge clk);
        end
        chk("b2b_end_frame", frame, 0);
        chk("b2b_end_done", done, 1);
        @(negedge clk);

        // pause for 5 cycles while bit 3 is on the line
        send(16'h00A5, 7, 1'b1, 8'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("pre_pause_bit", serial, bit_at(16'h00A5, 7, 1'b1, i));
            if (i < 3) @(negedge clk);
        end
        enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("pause_bit", serial, bit_at(16'h00A5, 7, 1'b1, 3));
            chk("pause_strobe", strobe, 0);
            chk("pause_frame", frame, 1);
        end
        enable = 1'b1;
        for (int i = 4; i < 8; i++) begin
            @(negedge clk);
            chk("post_pause_bit", serial, bit_at(16'h00A5, 7, 1'b1, i));
            chk("post_pause_strobe", strobe, 1);
        end
        @(negedge clk);
        chk("pause_done", done, 1);
        chk("pause_frame_end", frame, 0);
        @(negedge clk);

        // asynchronous reset during bit 4
        send(16'hF0F0, 15, 1'b1, 8'd3);
        @(negedge clk);
        repeat (16) @(negedge clk);
        chk("pre_rst_bit", serial, bit_at(16'hF0F0, 15, 1'b1, 4));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_frame", frame, 0);
        chk("arst_serial", serial, 0);
        chk("arst_ready", s_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_strobe", strobe, 0);
        repeat (2) @(negedge clk);
        chk("arst_done", done, 0);
        rst_n = 1'b1;
        nd0 = ndone;
        send(16'h000B, 3, 1'b0, 8'd0);
        chk("no_done_after_rst", ndone, nd0);
        expect_frame(16'h000B, 3, 1'b0, 0);

        // word accepted while disabled waits in the holding register
        enable = 1'b0;
        send(16'h003C, 5, 1'b0, 8'd1);
        chk("hold_ready", s_ready, 0);
        chk("hold_busy", busy, 1);
        repeat (5) begin
            @(negedge clk);
            chk("hold_frame", frame, 0);
            chk("hold_serial", serial, 0);
            chk("hold_strobe", strobe, 0);
        end
        enable = 1'b1;
        expect_frame(16'h003C, 5, 1'b0, 1);
        chk("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
